// File: rtl/spi_sched_pkg.sv
// Shared types for the SPI command scheduler: FSM states, grant owner, poll index width.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StRecover
    } sched_state_e;

    typedef enum logic {
        OwnHost = 1'b0,
        OwnPoll = 1'b1
    } owner_e;

    localparam int unsigned PollIdxW = 4;

endpackage

// File: rtl/spi_sched_poll_timer.sv
// Poll period counter, round tracking, poll entry pointer and sticky overrun flag.
module spi_sched_poll_timer
    import spi_sched_pkg::*;
#(
    parameter int unsigned POLL_NUM    = 4,
    parameter int unsigned POLL_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                poll_en,
    input  logic                busy,
    input  logic                advance,
    output logic                round_active,
    output logic [PollIdxW-1:0] poll_ptr,
    output logic                poll_overrun
);

    localparam int unsigned TimerW = $clog2(POLL_PERIOD);
    localparam logic [TimerW-1:0]   TimerMax = TimerW'(POLL_PERIOD - 1);
    localparam logic [PollIdxW-1:0] PtrLast  = PollIdxW'(POLL_NUM - 1);

    logic [TimerW-1:0] timer_q;
    logic              tick;

    assign tick = poll_en && (timer_q == TimerMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q      <= '0;
            round_active <= 1'b0;
            poll_ptr     <= '0;
            poll_overrun <= 1'b0;
        end else begin
            if (!poll_en || tick) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TimerW'(1);
            end

            if (!poll_en) begin
                poll_overrun <= 1'b0;
            end else if (tick && round_active) begin
                poll_overrun <= 1'b1;
            end

            if (advance) begin
                poll_ptr <= poll_ptr + PollIdxW'(1);
                if (poll_ptr == PtrLast) begin
                    round_active <= 1'b0;
                end
            end

            // A disabled round is only dropped once the in-flight transaction has retired.
            if (tick && !round_active) begin
                round_active <= 1'b1;
                poll_ptr     <= '0;
            end else if (!poll_en && !busy) begin
                round_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Shares one SPI drive between the host command port and the periodic poll engine,
// one transaction at a time, with timeout recovery.
module spi_cmd_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned DATA_WITH      = 29,
    parameter int unsigned READ_DATA_WITH = 29,
    parameter int unsigned POLL_NUM       = 4,
    parameter int unsigned POLL_PERIOD    = 100000,
    parameter int unsigned TIMEOUT        = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_req,
    input  logic                          host_rd,
    input  logic [DATA_WITH-1:0]          host_data,
    output logic                          host_ack,
    output logic                          host_done,
    output logic                          host_err,
    output logic [READ_DATA_WITH-1:0]     host_rd_data,
    output logic [READ_DATA_WITH-1:0]     host_rd_data_b,
    input  logic                          poll_en,
    input  logic [POLL_NUM*DATA_WITH-1:0] poll_cmd,
    output logic                          poll_vld,
    output logic [PollIdxW-1:0]           poll_idx,
    output logic [READ_DATA_WITH-1:0]     poll_rd_data,
    output logic [READ_DATA_WITH-1:0]     poll_rd_data_b,
    output logic                          poll_overrun,
    input  logic                          spi_ready,
    output logic                          spi_wr_req,
    output logic                          spi_rd_req,
    output logic [DATA_WITH-1:0]          spi_data,
    input  logic                          spi_wr_done,
    input  logic                          spi_rd_done,
    input  logic                          spi_rd_data_vld,
    input  logic [READ_DATA_WITH-1:0]     spi_rd_data,
    input  logic [READ_DATA_WITH-1:0]     spi_rd_data_b
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT);

    sched_state_e         state;
    owner_e               owner;
    owner_e               last_grant;
    logic                 is_rd;
    logic [WaitW-1:0]     wait_cnt;
    logic                 round_active;
    logic [PollIdxW-1:0]  poll_ptr;
    logic [DATA_WITH-1:0] poll_word;
    logic                 poll_pend;
    logic                 can_grant;
    logic                 grant_host;
    logic                 grant_poll;
    logic                 sel_rd;
    logic                 advance;

    always_comb begin
        poll_word = '0;
        for (int i = 0; i < POLL_NUM; i++) begin
            if (poll_ptr == PollIdxW'(i)) begin
                poll_word = poll_cmd[i*DATA_WITH +: DATA_WITH];
            end
        end
    end

    // Under contention the owner that did not win last time gets the drive.
    assign poll_pend  = round_active && poll_en;
    assign can_grant  = (state == StIdle) && spi_ready;
    assign grant_host = can_grant && host_req && (!poll_pend || last_grant == OwnPoll);
    assign grant_poll = can_grant && poll_pend && (!host_req || last_grant == OwnHost);
    assign sel_rd     = grant_poll || host_rd;
    assign advance    = (owner == OwnPoll) &&
                        ((state == StDone) || (state == StRecover && spi_ready));

    spi_sched_poll_timer #(
        .POLL_NUM    (POLL_NUM),
        .POLL_PERIOD (POLL_PERIOD)
    ) u_poll_timer (
        .clk          (clk),
        .rst          (rst),
        .poll_en      (poll_en),
        .busy         (state != StIdle),
        .advance      (advance),
        .round_active (round_active),
        .poll_ptr     (poll_ptr),
        .poll_overrun (poll_overrun)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            owner          <= OwnHost;
            last_grant     <= OwnPoll;
            is_rd          <= 1'b0;
            wait_cnt       <= '0;
            spi_data       <= '0;
            spi_wr_req     <= 1'b0;
            spi_rd_req     <= 1'b0;
            host_ack       <= 1'b0;
            host_done      <= 1'b0;
            host_err       <= 1'b0;
            host_rd_data   <= '0;
            host_rd_data_b <= '0;
            poll_vld       <= 1'b0;
            poll_idx       <= '0;
            poll_rd_data   <= '0;
            poll_rd_data_b <= '0;
        end else begin
            spi_wr_req <= 1'b0;
            spi_rd_req <= 1'b0;
            host_ack   <= 1'b0;
            host_done  <= 1'b0;
            host_err   <= 1'b0;
            poll_vld   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grant_host || grant_poll) begin
                        state      <= StIssue;
                        owner      <= grant_poll ? OwnPoll : OwnHost;
                        last_grant <= grant_poll ? OwnPoll : OwnHost;
                        spi_data   <= grant_poll ? poll_word : host_data;
                        is_rd      <= sel_rd;
                        spi_rd_req <= sel_rd;
                        spi_wr_req <= !sel_rd;
                        host_ack   <= grant_host;
                    end
                end
                StIssue: begin
                    state    <= StWait;
                    wait_cnt <= WaitW'(1);
                end
                StWait: begin
                    if (is_rd && spi_rd_data_vld) begin
                        if (owner == OwnHost) begin
                            host_rd_data   <= spi_rd_data;
                            host_rd_data_b <= spi_rd_data_b;
                        end else begin
                            poll_rd_data   <= spi_rd_data;
                            poll_rd_data_b <= spi_rd_data_b;
                        end
                    end
                    if (is_rd ? spi_rd_done : spi_wr_done) begin
                        state     <= StDone;
                        host_done <= (owner == OwnHost);
                        poll_vld  <= (owner == OwnPoll);
                        poll_idx  <= poll_ptr;
                    end else if (wait_cnt == TimeoutVal) begin
                        state <= StRecover;
                    end else begin
                        wait_cnt <= wait_cnt + WaitW'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                StRecover: begin
                    // A timed-out poll entry is skipped silently; the host is told.
                    if (spi_ready) begin
                        state     <= StIdle;
                        host_done <= (owner == OwnHost);
                        host_err  <= (owner == OwnHost);
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Directed bench for spi_cmd_scheduler with an SPI drive stub and an ordered result scoreboard.
module tb_spi_cmd_scheduler;

    localparam int DW = 29;
    localparam int RW = 29;
    localparam int PN = 4;
    localparam int PP = 50;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             host_req = 1'b0;
    logic             host_rd = 1'b0;
    logic [DW-1:0]    host_data = '0;
    logic             host_ack, host_done, host_err;
    logic [RW-1:0]    host_rd_data, host_rd_data_b;
    logic             poll_en = 1'b0;
    logic [PN*DW-1:0] poll_cmd;
    logic             poll_vld;
    logic [3:0]       poll_idx;
    logic [RW-1:0]    poll_rd_data, poll_rd_data_b;
    logic             poll_overrun;
    logic             spi_ready = 1'b1;
    logic             spi_wr_req, spi_rd_req;
    logic [DW-1:0]    spi_data;
    logic             spi_wr_done = 1'b0;
    logic             spi_rd_done = 1'b0;
    logic             spi_rd_data_vld = 1'b0;
    logic [RW-1:0]    spi_rd_data = '0;
    logic [RW-1:0]    spi_rd_data_b = '0;

    spi_cmd_scheduler #(
        .DATA_WITH      (DW),
        .READ_DATA_WITH (RW),
        .POLL_NUM       (PN),
        .POLL_PERIOD    (PP),
        .TIMEOUT        (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .host_req        (host_req),
        .host_rd         (host_rd),
        .host_data       (host_data),
        .host_ack        (host_ack),
        .host_done       (host_done),
        .host_err        (host_err),
        .host_rd_data    (host_rd_data),
        .host_rd_data_b  (host_rd_data_b),
        .poll_en         (poll_en),
        .poll_cmd        (poll_cmd),
        .poll_vld        (poll_vld),
        .poll_idx        (poll_idx),
        .poll_rd_data    (poll_rd_data),
        .poll_rd_data_b  (poll_rd_data_b),
        .poll_overrun    (poll_overrun),
        .spi_ready       (spi_ready),
        .spi_wr_req      (spi_wr_req),
        .spi_rd_req      (spi_rd_req),
        .spi_data        (spi_data),
        .spi_wr_done     (spi_wr_done),
        .spi_rd_done     (spi_rd_done),
        .spi_rd_data_vld (spi_rd_data_vld),
        .spi_rd_data     (spi_rd_data),
        .spi_rd_data_b   (spi_rd_data_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_poll;
        bit          err;
        bit          chk_data;
        logic [3:0]  idx;
        logic [RW-1:0] a;
        logic [RW-1:0] b;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          m;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            last_done_cyc = 0;
    int            host_done_seen = 0;
    int            proto_bad = 0;
    int            stab_bad = 0;
    logic [DW-1:0] pw [PN];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] f_a(input logic [DW-1:0] d);
        return d ^ 29'h15555555;
    endfunction

    function automatic logic [RW-1:0] f_b(input logic [DW-1:0] d);
        return {d[13:0], d[28:14]};
    endfunction

    task automatic push_host(input bit err, input bit chk, input logic [RW-1:0] a,
                             input logic [RW-1:0] b);
        exp_t e;
        e.is_poll = 1'b0; e.err = err; e.chk_data = chk; e.idx = '0; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic push_poll(input int i);
        exp_t e;
        e.is_poll = 1'b1; e.err = 1'b0; e.chk_data = 1'b1; e.idx = 4'(i);
        e.a = f_a(pw[i]); e.b = f_b(pw[i]);
        exp_q.push_back(e);
    endtask

    // SPI drive stub: latches the request, answers after stub_delay cycles unless hung.
    int            stub_delay = 4;
    bit            stub_hang = 1'b0;
    bit            stub_fixed = 1'b0;
    logic [RW-1:0] fixed_a = '0;
    logic [RW-1:0] fixed_b = '0;
    bit            sbusy = 1'b0;
    bit            s_rd = 1'b0;
    int            scnt = 0;
    logic [DW-1:0] s_lat = '0;

    always @(negedge clk) begin
        spi_wr_done     = 1'b0;
        spi_rd_done     = 1'b0;
        spi_rd_data_vld = 1'b0;
        if (rst) begin
            sbusy     = 1'b0;
            spi_ready = 1'b1;
        end else if (spi_wr_req || spi_rd_req) begin
            if (sbusy || (spi_wr_req && spi_rd_req)) proto_bad++;
            sbusy     = 1'b1;
            spi_ready = 1'b0;
            s_rd      = spi_rd_req;
            s_lat     = spi_data;
            scnt      = stub_delay;
        end else if (sbusy) begin
            if (spi_data !== s_lat) stab_bad++;
            if (!stub_hang) begin
                if (scnt <= 1) begin
                    sbusy         = 1'b0;
                    spi_ready     = 1'b1;
                    last_done_cyc = cyc;
                    if (s_rd) begin
                        spi_rd_done     = 1'b1;
                        spi_rd_data_vld = 1'b1;
                        spi_rd_data     = stub_fixed ? fixed_a : f_a(s_lat);
                        spi_rd_data_b   = stub_fixed ? fixed_b : f_b(s_lat);
                    end else begin
                        spi_wr_done = 1'b1;
                    end
                end else begin
                    scnt--;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (host_done || poll_vld) begin
            if (host_done) host_done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'({host_done, poll_vld}), 64'(0));
            end else begin
                m = exp_q.pop_front();
                check("both_done", 64'(host_done & poll_vld), 64'(0));
                check("owner", 64'(poll_vld), 64'(m.is_poll));
                if (m.is_poll) begin
                    check("poll_idx", 64'(poll_idx), 64'(m.idx));
                    check("poll_rd_a", 64'(poll_rd_data), 64'(m.a));
                    check("poll_rd_b", 64'(poll_rd_data_b), 64'(m.b));
                end else begin
                    check("host_err", 64'(host_err), 64'(m.err));
                    if (m.chk_data) begin
                        check("host_rd_a", 64'(host_rd_data), 64'(m.a));
                        check("host_rd_b", 64'(host_rd_data_b), 64'(m.b));
                    end
                end
                if (!m.err) check("done_latency", 64'(cyc), 64'(last_done_cyc + 1));
            end
        end
    end

    task automatic host_txn(input bit rd, input logic [DW-1:0] d, input int bound);
        int i;
        @(negedge clk);
        host_req  = 1'b1;
        host_rd   = rd;
        host_data = d;
        for (i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (host_ack) break;
        end
        check("host_ack_seen", 64'(host_ack), 64'(1));
        check("req_kind", 64'({spi_rd_req, spi_wr_req}), rd ? 64'(2) : 64'(1));
        @(negedge clk);
        host_req = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        pw[0] = 29'h1A5A5A5;
        pw[1] = 29'h0246802;
        pw[2] = 29'h1357913;
        pw[3] = 29'h0C0FFEE;
        for (int i = 0; i < PN; i++) poll_cmd[i*DW +: DW] = pw[i];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_host_ack", 64'(host_ack), 64'(0));
        check("rst_host_done", 64'(host_done), 64'(0));
        check("rst_host_err", 64'(host_err), 64'(0));
        check("rst_host_rd", 64'(host_rd_data), 64'(0));
        check("rst_wr_req", 64'(spi_wr_req), 64'(0));
        check("rst_rd_req", 64'(spi_rd_req), 64'(0));
        check("rst_spi_data", 64'(spi_data), 64'(0));
        check("rst_poll_vld", 64'(poll_vld), 64'(0));
        check("rst_poll_idx", 64'(poll_idx), 64'(0));
        check("rst_overrun", 64'(poll_overrun), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Host write, 60-cycle drive
        stub_delay = 60;
        push_host(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        host_req  = 1'b1;
        host_rd   = 1'b0;
        host_data = 29'h0ABCDEF;
        @(posedge clk);
        #1;
        check("w_ack", 64'(host_ack), 64'(1));
        check("w_wr_req", 64'(spi_wr_req), 64'(1));
        check("w_rd_req", 64'(spi_rd_req), 64'(0));
        check("w_spi_data", 64'(spi_data), 64'(29'h0ABCDEF));
        @(negedge clk);
        host_req = 1'b0;
        @(posedge clk);
        #1;
        check("w_ack_pulse", 64'(host_ack), 64'(0));
        check("w_wr_pulse", 64'(spi_wr_req), 64'(0));
        check("w_data_hold", 64'(spi_data), 64'(29'h0ABCDEF));
        wait_drain(200);

        // Host read with fixed lane data
        stub_delay = 5;
        stub_fixed = 1'b1;
        fixed_a    = 29'h1234567;
        fixed_b    = 29'h0765432;
        push_host(1'b0, 1'b1, 29'h1234567, 29'h0765432);
        host_txn(1'b1, 29'h1F00001, 20);
        wait_drain(50);
        stub_fixed = 1'b0;

        // Timeout: drive never answers until released
        stub_delay = 2;
        stub_hang  = 1'b1;
        push_host(1'b1, 1'b0, '0, '0);
        host_txn(1'b0, 29'h0DEAD01, 20);
        repeat (90) @(negedge clk);
        check("no_done_while_hung", 64'(exp_q.size()), 64'(1));
        check("recover_data_hold", 64'(spi_data), 64'(29'h0DEAD01));
        stub_hang = 1'b0;
        wait_drain(20);

        // Alternating grants with a continuously requesting host
        stub_delay = 8;
        for (int k = 0; k < PN; k++) begin
            push_host(1'b0, 1'b0, '0, '0);
            push_poll(k);
        end
        @(negedge clk);
        poll_en = 1'b1;
        repeat (44) @(negedge clk);
        for (int k = 0; k < PN; k++) host_txn(1'b0, 29'h100 + 29'(k), 200);
        wait_drain(300);
        poll_en = 1'b0;
        @(posedge clk);
        #1;
        check("overrun_clr_alt", 64'(poll_overrun), 64'(0));

        // Overrun: 30-cycle transactions against a 50-cycle period
        stub_delay = 30;
        for (int k = 0; k < PN; k++) push_poll(k);
        @(negedge clk);
        poll_en = 1'b1;
        wait_drain(700);
        check("overrun_set", 64'(poll_overrun), 64'(1));
        poll_en = 1'b0;
        @(posedge clk);
        #1;
        check("overrun_clr", 64'(poll_overrun), 64'(0));

        // Reset in the middle of WAIT
        stub_delay = 40;
        begin
            int seen;
            seen = host_done_seen;
            host_txn(1'b0, 29'h0555AAA, 20);
            repeat (5) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("mid_rst_ack", 64'(host_ack), 64'(0));
            check("mid_rst_done", 64'(host_done), 64'(0));
            check("mid_rst_wr_req", 64'(spi_wr_req), 64'(0));
            check("mid_rst_spi_data", 64'(spi_data), 64'(0));
            check("mid_rst_poll_vld", 64'(poll_vld), 64'(0));
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            repeat (60) @(negedge clk);
            check("no_done_after_rst", 64'(host_done_seen), 64'(seen));
        end
        stub_delay = 3;
        for (int k = 0; k < PN; k++) push_poll(k);
        poll_en = 1'b1;
        wait_drain(300);
        poll_en = 1'b0;
        repeat (5) @(negedge clk);

        check("protocol", 64'(proto_bad), 64'(0));
        check("spi_data_stable", 64'(stab_bad), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
